// File: rtl/bus_arbiter.sv
// Shared single-port memory arbiter for instruction fetch and data accesses.
// Data wins by default; a fetch is forced through after STARVE_LIMIT data grants.
module bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wstrb,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        pc_stall,
  output logic        mem_stall
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_BUSY = 2'd1;
  localparam logic [1:0] DM_BUSY = 2'd2;

  localparam logic [2:0] StarveMax = 3'(STARVE_LIMIT);

  logic [1:0]  state_q, state_d;
  logic [2:0]  starve_cnt_q, starve_cnt_d;
  logic        discard_q, discard_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;

  logic in_if, in_dm, arb_en, fetch_forced, grant_dm, grant_if;

  assign in_if = (state_q == IF_BUSY);
  assign in_dm = (state_q == DM_BUSY);

  // Only one transaction may be outstanding, so re-arbitrate only when idle or on completion.
  assign arb_en       = (state_q == IDLE) | mem_ack;
  assign fetch_forced = if_req & (starve_cnt_q == StarveMax);
  assign grant_dm     = arb_en & dm_req & ~fetch_forced;
  assign grant_if     = arb_en & if_req & ~grant_dm;

  assign dm_ready  = mem_ack & in_dm;
  assign dm_rdata  = mem_rdata;
  assign if_ready  = mem_ack & in_if & ~discard_q & ~flush;
  assign if_rdata  = mem_rdata;
  assign pc_stall  = if_req & ~if_ready;
  assign mem_stall = dm_req & ~dm_ready;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    discard_d    = discard_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;

    // A flushed fetch still completes on the bus; its data is just never reported.
    if (in_if && mem_ack) begin
      discard_d = 1'b0;
    end else if (in_if && flush) begin
      discard_d = 1'b1;
    end

    if (arb_en) begin
      if (grant_dm) begin
        state_d     = DM_BUSY;
        mem_req_d   = 1'b1;
        mem_we_d    = dm_we;
        mem_addr_d  = dm_addr;
        mem_wdata_d = dm_wdata;
        mem_wstrb_d = dm_wstrb;
        if (if_req) begin
          starve_cnt_d = (starve_cnt_q == StarveMax) ? StarveMax : starve_cnt_q + 3'd1;
        end
      end else if (grant_if) begin
        state_d      = IF_BUSY;
        mem_req_d    = 1'b1;
        mem_we_d     = 1'b0;
        mem_addr_d   = if_addr;
        mem_wdata_d  = 32'h0;
        mem_wstrb_d  = 4'b0000;
        starve_cnt_d = 3'd0;
      end else begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= 3'd0;
      discard_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_wstrb_q  <= 4'b0000;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      discard_q    <= discard_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbitration rules.
module tb_bus_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req, dm_req, dm_we, flush, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_wstrb;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, dm_ready, mem_req, mem_we, pc_stall, mem_stall;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc_stall(pc_stall), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    dm_wstrb = 0; flush = 0; mem_ack = 0; mem_rdata = 0;
  endtask

  // Leaves the bench at a falling edge with rst_n just released.
  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic drain();
    if_req = 0; dm_req = 0; flush = 0;
    for (int i = 0; i < 20 && mem_req === 1'b1; i++) begin
      mem_ack = 1;
      @(negedge clk);
    end
    mem_ack = 0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL drain_idle: mem_req=%b, want 0", mem_req);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    #3;
    rst_n = 0; if_req = 1; dm_req = 1; mem_ack = 1;
    #1;
    checks++;
    if (mem_req !== 0 || mem_we !== 0 || mem_addr !== 0 || mem_wdata !== 0 || mem_wstrb !== 0) begin
      errors++;
      $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h wstrb=%h, want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
    end
    checks++;
    if (if_ready !== 0 || dm_ready !== 0) begin
      errors++; $display("FAIL reset_ready: if_ready=%b dm_ready=%b, want 0 0", if_ready, dm_ready);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 0) begin
      errors++; $display("FAIL reset_hold: mem_req=%b, want 0", mem_req);
    end
  endtask

  task automatic test_single_fetch();
    apply_reset();
    if_req = 1; if_addr = 32'h100;
    #1;
    checks++;
    if (mem_req !== 0 || pc_stall !== 1) begin
      errors++; $display("FAIL fetch_pre: mem_req=%b pc_stall=%b, want 0 1", mem_req, pc_stall);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1 || mem_addr !== 32'h100 || mem_we !== 0 || mem_wstrb !== 4'h0) begin
      errors++;
      $display("FAIL fetch_issue: req=%b addr=%h we=%b wstrb=%h, want 1 00000100 0 0",
               mem_req, mem_addr, mem_we, mem_wstrb);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1 || if_ready !== 0) begin
      errors++; $display("FAIL fetch_wait: mem_req=%b if_ready=%b, want 1 0", mem_req, if_ready);
    end
    @(negedge clk);
    mem_ack = 1; mem_rdata = 32'h00500093;
    #1;
    checks++;
    if (if_ready !== 1 || if_rdata !== 32'h00500093 || pc_stall !== 0) begin
      errors++;
      $display("FAIL fetch_done: if_ready=%b if_rdata=%h pc_stall=%b, want 1 00500093 0",
               if_ready, if_rdata, pc_stall);
    end
    if_req = 0;
    @(negedge clk);
    mem_ack = 0;
    #1;
    checks++;
    if (mem_req !== 0 || if_ready !== 0) begin
      errors++; $display("FAIL fetch_idle: mem_req=%b if_ready=%b, want 0 0", mem_req, if_ready);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    if_req = 1; if_addr = 32'h104;
    dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF; dm_wstrb = 4'hF;
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1 || mem_we !== 1 || mem_addr !== 32'h2000 || mem_wdata !== 32'hDEADBEEF ||
        mem_wstrb !== 4'hF) begin
      errors++;
      $display("FAIL simul_store: req=%b we=%b addr=%h wdata=%h wstrb=%h, want 1 1 2000 deadbeef f",
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
    end
    checks++;
    if (mem_stall !== 1 || pc_stall !== 1) begin
      errors++; $display("FAIL simul_stall: mem_stall=%b pc_stall=%b, want 1 1", mem_stall, pc_stall);
    end
    mem_ack = 1;
    #1;
    checks++;
    if (dm_ready !== 1 || if_ready !== 0 || mem_stall !== 0) begin
      errors++;
      $display("FAIL simul_dm_done: dm_ready=%b if_ready=%b mem_stall=%b, want 1 0 0",
               dm_ready, if_ready, mem_stall);
    end
    dm_req = 0;
    @(negedge clk);
    mem_ack = 0;
    #1;
    checks++;
    if (mem_req !== 1 || mem_we !== 0 || mem_addr !== 32'h104 || mem_wstrb !== 4'h0) begin
      errors++;
      $display("FAIL simul_fetch: req=%b we=%b addr=%h wstrb=%h, want 1 0 00000104 0",
               mem_req, mem_we, mem_addr, mem_wstrb);
    end
    mem_ack = 1; mem_rdata = 32'h12345678;
    #1;
    checks++;
    if (if_ready !== 1 || if_rdata !== 32'h12345678) begin
      errors++; $display("FAIL simul_if_done: if_ready=%b rdata=%h, want 1 12345678", if_ready, if_rdata);
    end
    if_req = 0;
    @(negedge clk);
    mem_ack = 0;
  endtask

  task automatic test_starvation();
    apply_reset();
    if_req = 1; if_addr = 32'h3000;
    dm_req = 1; dm_we = 0; dm_addr = 32'h4000; dm_wdata = 0; dm_wstrb = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 10; cyc++) begin
      mem_ack = 1; mem_rdata = cyc;
      #1;
      checks++;
      if (mem_req !== 1 || (mem_addr[15:12] == 4'h3) !== (cyc % 5 == 4) || if_ready !== (cyc % 5 == 4)) begin
        errors++;
        $display("FAIL starve_grant%0d: req=%b addr=%h if_ready=%b, want fetch=%0d",
                 cyc, mem_req, mem_addr, if_ready, (cyc % 5 == 4));
      end
      if (dm_ready === 1'b1) dm_addr = dm_addr + 4;
      if (if_ready === 1'b1) if_addr = if_addr + 4;
      @(negedge clk);
    end
    drain();
  endtask

  task automatic test_flush();
    apply_reset();
    if_req = 1; if_addr = 32'h500;
    @(negedge clk);
    flush = 1; if_addr = 32'h600;
    #1;
    checks++;
    if (pc_stall !== 1 || if_ready !== 0) begin
      errors++; $display("FAIL flush_pulse: pc_stall=%b if_ready=%b, want 1 0", pc_stall, if_ready);
    end
    @(negedge clk);
    flush = 0;
    @(negedge clk);
    mem_ack = 1; mem_rdata = 32'h11111111;
    #1;
    checks++;
    if (if_ready !== 0 || pc_stall !== 1) begin
      errors++; $display("FAIL flush_discard: if_ready=%b pc_stall=%b, want 0 1", if_ready, pc_stall);
    end
    @(negedge clk);
    mem_ack = 0;
    #1;
    checks++;
    if (mem_req !== 1 || mem_addr !== 32'h600 || pc_stall !== 1) begin
      errors++;
      $display("FAIL flush_refetch: req=%b addr=%h pc_stall=%b, want 1 00000600 1",
               mem_req, mem_addr, pc_stall);
    end
    mem_ack = 1; mem_rdata = 32'h22222222;
    #1;
    checks++;
    if (if_ready !== 1 || if_rdata !== 32'h22222222 || pc_stall !== 0) begin
      errors++;
      $display("FAIL flush_refetch_done: if_ready=%b rdata=%h pc_stall=%b, want 1 22222222 0",
               if_ready, if_rdata, pc_stall);
    end
    if_req = 0;
    @(negedge clk);
    mem_ack = 0;
  endtask

  task automatic test_flush_on_ack();
    apply_reset();
    if_req = 1; if_addr = 32'h700;
    @(negedge clk);
    mem_ack = 1; flush = 1; if_addr = 32'h800;
    #1;
    checks++;
    if (if_ready !== 0 || pc_stall !== 1) begin
      errors++; $display("FAIL flush_ack: if_ready=%b pc_stall=%b, want 0 1", if_ready, pc_stall);
    end
    @(negedge clk);
    mem_ack = 0; flush = 0;
    #1;
    checks++;
    if (mem_req !== 1 || mem_addr !== 32'h800) begin
      errors++; $display("FAIL flush_ack_refetch: req=%b addr=%h, want 1 00000800", mem_req, mem_addr);
    end
    mem_ack = 1;
    #1;
    checks++;
    if (if_ready !== 1) begin
      errors++; $display("FAIL flush_ack_done: if_ready=%b, want 1", if_ready);
    end
    if_req = 0;
    @(negedge clk);
    mem_ack = 0;
  endtask

  task automatic test_flush_in_dm();
    apply_reset();
    dm_req = 1; dm_we = 0; dm_addr = 32'h8000; if_req = 1; if_addr = 32'h900;
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0; mem_ack = 1;
    #1;
    checks++;
    if (dm_ready !== 1 || mem_addr !== 32'h8000) begin
      errors++; $display("FAIL flush_dm: dm_ready=%b addr=%h, want 1 00008000", dm_ready, mem_addr);
    end
    dm_req = 0;
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1 || mem_addr !== 32'h900 || if_ready !== 1) begin
      errors++;
      $display("FAIL flush_dm_fetch: req=%b addr=%h if_ready=%b, want 1 00000900 1",
               mem_req, mem_addr, if_ready);
    end
    if_req = 0;
    @(negedge clk);
    mem_ack = 0;
  endtask

  task automatic test_abandoned_request();
    apply_reset();
    dm_req = 1; dm_we = 1; dm_addr = 32'hA000; dm_wdata = 32'hCAFEF00D; dm_wstrb = 4'h3;
    @(negedge clk);
    checks++;
    if (mem_we !== 1 || mem_wstrb !== 4'h3 || mem_wdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL abandon_store: we=%b wstrb=%h wdata=%h, want 1 3 cafef00d", mem_we, mem_wstrb, mem_wdata);
    end
    if_req = 1; if_addr = 32'hB000;
    @(negedge clk);
    if_req = 0; mem_ack = 1;
    #1;
    dm_req = 0;
    @(negedge clk);
    mem_ack = 0;
    #1;
    checks++;
    if (mem_req !== 0) begin
      errors++; $display("FAIL abandon_idle: mem_req=%b, want 0", mem_req);
    end
    dm_req = 1; dm_we = 0; dm_addr = 32'hC000;
    @(negedge clk);
    mem_ack = 1; mem_rdata = 32'h0BADCAFE;
    #1;
    checks++;
    if (mem_addr !== 32'hC000 || dm_ready !== 1 || dm_rdata !== 32'h0BADCAFE) begin
      errors++;
      $display("FAIL abandon_next: addr=%h dm_ready=%b rdata=%h, want 0000c000 1 0badcafe",
               mem_addr, dm_ready, dm_rdata);
    end
    dm_req = 0;
    @(negedge clk);
    mem_ack = 0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    dm_req = 1; dm_we = 1; dm_addr = 32'hD000; dm_wdata = 32'h55AA55AA; dm_wstrb = 4'hF;
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if (mem_req !== 0 || mem_we !== 0 || mem_addr !== 0 || dm_ready !== 0) begin
      errors++;
      $display("FAIL reset_mid: req=%b we=%b addr=%h dm_ready=%b, want 0 0 0 0",
               mem_req, mem_we, mem_addr, dm_ready);
    end
    dm_req = 0;
    @(negedge clk);
    rst_n = 1; mem_ack = 1;
    #1;
    checks++;
    if (dm_ready !== 0) begin
      errors++; $display("FAIL reset_late_ack: dm_ready=%b, want 0", dm_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 0) begin
      errors++; $display("FAIL reset_late_idle: mem_req=%b, want 0", mem_req);
    end
    mem_ack = 0;
    dm_req = 1; dm_we = 0; dm_addr = 32'hE000;
    @(negedge clk);
    mem_ack = 1; mem_rdata = 32'h600DD00D;
    #1;
    checks++;
    if (mem_addr !== 32'hE000 || dm_ready !== 1 || dm_rdata !== 32'h600DD00D) begin
      errors++;
      $display("FAIL reset_next: addr=%h dm_ready=%b rdata=%h, want 0000e000 1 600dd00d",
               mem_addr, dm_ready, dm_rdata);
    end
    dm_req = 0;
    @(negedge clk);
    mem_ack = 0;
  endtask

  // Model: one transaction owner (0 none, 1 fetch, 2 data) and the number of data grants
  // that have overtaken a waiting fetch since the last fetch grant.
  task automatic test_random();
    int          owner, run;
    bit          disc, e_if, e_dm;
    logic [31:0] e_addr, e_wdata;
    logic        e_we;
    logic [3:0]  e_wstrb;
    apply_reset();
    owner = 0; run = 0; disc = 0; e_addr = 0; e_wdata = 0; e_we = 0; e_wstrb = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      mem_ack   = ($urandom_range(0, 1) == 1);
      mem_rdata = $urandom();
      flush     = ($urandom_range(0, 11) == 0);
      e_if = mem_ack && owner == 1 && !disc && !flush;
      e_dm = mem_ack && owner == 2;
      if (if_req && e_if) begin
        if_req = ($urandom_range(0, 1) == 1); if_addr = $urandom();
      end else if (flush) begin
        if_req = 1; if_addr = $urandom();
      end else if (!if_req) begin
        if_req = ($urandom_range(0, 2) == 0); if_addr = $urandom();
      end
      if ((dm_req && e_dm) || !dm_req) begin
        dm_req   = (dm_req && e_dm) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
        dm_we    = ($urandom_range(0, 1) == 1);
        dm_addr  = $urandom();
        dm_wdata = $urandom();
        dm_wstrb = 4'($urandom_range(0, 15));
      end
      #1;
      checks++;
      if (if_ready !== e_if || dm_ready !== e_dm) begin
        errors++;
        $display("FAIL rand_ready cyc%0d: if_ready=%b dm_ready=%b, want %b %b",
                 cyc, if_ready, dm_ready, e_if, e_dm);
      end
      checks++;
      if (pc_stall !== (if_req && !e_if) || mem_stall !== (dm_req && !e_dm)) begin
        errors++;
        $display("FAIL rand_stall cyc%0d: pc_stall=%b mem_stall=%b, want %b %b",
                 cyc, pc_stall, mem_stall, (if_req && !e_if), (dm_req && !e_dm));
      end
      checks++;
      if (mem_req !== (owner != 0)) begin
        errors++; $display("FAIL rand_mem_req cyc%0d: mem_req=%b, want %b", cyc, mem_req, (owner != 0));
      end
      if (owner != 0) begin
        checks++;
        if (mem_addr !== e_addr || mem_we !== e_we || mem_wstrb !== e_wstrb ||
            (owner == 2 && mem_wdata !== e_wdata)) begin
          errors++;
          $display("FAIL rand_mem_bus cyc%0d: addr=%h we=%b wstrb=%h wdata=%h, want %h %b %h %h",
                   cyc, mem_addr, mem_we, mem_wstrb, mem_wdata, e_addr, e_we, e_wstrb, e_wdata);
        end
      end
      if (e_if || e_dm) begin
        checks++;
        if ((e_if && if_rdata !== mem_rdata) || (e_dm && dm_rdata !== mem_rdata)) begin
          errors++;
          $display("FAIL rand_rdata cyc%0d: if_rdata=%h dm_rdata=%h, want %h",
                   cyc, if_rdata, dm_rdata, mem_rdata);
        end
      end
      if (owner == 1 && mem_ack) disc = 0;
      else if (owner == 1 && flush) disc = 1;
      if (owner == 0 || mem_ack) begin
        if (dm_req && !(if_req && run >= LIMIT)) begin
          owner = 2; e_addr = dm_addr; e_we = dm_we; e_wdata = dm_wdata; e_wstrb = dm_wstrb;
          if (if_req && run < LIMIT) run++;
        end else if (if_req) begin
          owner = 1; e_addr = if_addr; e_we = 0; e_wstrb = 4'h0; run = 0;
        end else begin
          owner = 0;
        end
      end
      @(negedge clk);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_flush();
    test_flush_on_ack();
    test_flush_in_dm();
    test_abandoned_request();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive data grants allowed while a fetch waits.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  fetch request, held until if_ready; if_addr  input  32  fetch address.
REQ-005 if_rdata  output  32  fetch data; if_ready  output  1  one-cycle fetch-complete pulse.
REQ-006 dm_req  input  1  data request, held until dm_ready; dm_we  input  1  write enable; dm_addr  input  32  address; dm_wdata  input  32  write data; dm_wstrb  input  4  byte strobes.
REQ-007 dm_rdata  output  32  load data; dm_ready  output  1  one-cycle data-complete pulse.
REQ-008 flush  input  1  branch taken; discards any in-flight fetch.
REQ-009 mem_req  output  1; mem_we  output  1; mem_addr  output  32; mem_wdata  output  32; mem_wstrb  output  4  single shared memory port, all registered.
REQ-010 mem_rdata  input  32; mem_ack  input  1  slave completion, valid for one cycle.
REQ-011 pc_stall  output  1  and  mem_stall  output  1  pipeline stall requests.

Function
REQ-012 SHALL implement FSM states IDLE, IF_BUSY, DM_BUSY, with at most one outstanding memory transaction.
REQ-013 Arbitration, evaluated in IDLE and on any cycle with mem_ack high: dm_req wins over if_req, except fetch wins when starve_cnt == STARVE_LIMIT.
REQ-014 On a grant, the FSM SHALL latch the winner's address, we, wdata and wstrb into mem_* and set mem_req=1 on the next edge; a fetch grant forces mem_we=0 and mem_wstrb=4'b0000.
REQ-015 mem_req and all mem_* outputs SHALL stay stable while in a BUSY state until the cycle mem_ack is sampled high.
REQ-016 On mem_ack, the FSM SHALL go to the next arbitrated BUSY state, or to IDLE (mem_req=0) when no request is pending.
REQ-017 Back-to-back transactions SHALL therefore need no IDLE cycle.
REQ-018 Latency: request at cycle N with the FSM idle gives mem_req at N+1; if mem_ack arrives at N+k (k>=1), ready is asserted at N+k.
REQ-019 dm_ready = mem_ack & DM_BUSY; dm_rdata = mem_rdata; combinational, valid only while dm_ready.
REQ-020 if_ready = mem_ack & IF_BUSY & ~discard & ~flush; if_rdata = mem_rdata.
REQ-021 discard flag: set by flush in IF_BUSY, cleared on leaving IF_BUSY; flush in IDLE or DM_BUSY has no effect.
REQ-022 A discarded fetch SHALL still wait for its mem_ack before the next grant; the transaction is never abandoned on the bus.
REQ-023 starve_cnt (3-bit) SHALL increment, saturating at STARVE_LIMIT, on each data grant made while if_req=1, and clear to 0 on each fetch grant.
REQ-024 pc_stall = if_req & ~if_ready; mem_stall = dm_req & ~dm_ready.
REQ-025 A request deasserted before grant (illegal per REQ-004/006) SHALL be ignored without a lockup.

Reset
REQ-026 rst_n low SHALL asynchronously force: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, starve_cnt=0, discard=0.
REQ-027 if_ready and dm_ready SHALL be 0 during reset.
REQ-028 Reset mid-transaction SHALL drop the transaction; a later mem_ack arriving in IDLE SHALL be ignored.
REQ-029 The first grant SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-030 Single fetch: if_req=1, if_addr=0x100, ack 2 cycles after mem_req, mem_rdata=0x00500093 -> mem_addr=0x100, mem_we=0, if_ready pulse with if_rdata=0x00500093, pc_stall low in the same cycle.
REQ-031 Simultaneous requests: if_req and dm_req (store 0xDEADBEEF to 0x2000, wstrb=0xF) in the same cycle -> data first with mem_we=1, then fetch granted in the ack cycle with no idle gap.
REQ-032 Starvation: dm_req held continuously with if_req=1, ack every cycle -> exactly 4 data grants, then one fetch grant, starve_cnt back to 0.
REQ-033 Flush: flush pulsed 1 cycle into IF_BUSY, then ack -> no if_ready, pc_stall stays 1 until the refetch completes.
REQ-034 Flush coincident with mem_ack -> if_ready stays 0.
REQ-035 Reset: rst_n low in DM_BUSY, then mem_ack asserted during IDLE after release -> mem_req=0, dm_ready=0, next request served normally.
